// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter that time-shares one external W-bit AND unit among four
// requesters: grant, execute through registered gate operands, respond.
module and_unit_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [3:0]         Req,
    input  logic [4*WIDTH-1:0] A_bus,
    input  logic [4*WIDTH-1:0] B_bus,
    output logic [3:0]         Grant,
    output logic [3:0]         Done,
    output logic [WIDTH-1:0]   F_out,
    output logic               Busy,
    output logic [15:0]        OpCount,
    output logic [WIDTH-1:0]   GateA,
    output logic [WIDTH-1:0]   GateB,
    input  logic [WIDTH-1:0]   GateF
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state, state_next;
    logic [1:0]         last, last_next;
    logic [1:0]         sel, sel_next;
    logic [3:0]         grant, grant_next;
    logic [3:0]         done, done_next;
    logic [WIDTH-1:0]   f_out, f_out_next;
    logic [15:0]        op_count, op_count_next;
    logic [WIDTH-1:0]   gate_a, gate_a_next;
    logic [WIDTH-1:0]   gate_b, gate_b_next;

    logic [1:0]         pick;
    logic [1:0]         cand;
    logic               found;

    // Scan requesters starting just after the last one served, so it ends up lowest priority.
    always_comb begin
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int k = 1; k < 5; k++) begin
            cand = last + 2'(k);
            if (!found && Req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            last     <= 2'd3;
            sel      <= 2'd0;
            grant    <= '0;
            done     <= '0;
            f_out    <= '0;
            op_count <= '0;
            gate_a   <= '0;
            gate_b   <= '0;
        end else begin
            state    <= state_next;
            last     <= last_next;
            sel      <= sel_next;
            grant    <= grant_next;
            done     <= done_next;
            f_out    <= f_out_next;
            op_count <= op_count_next;
            gate_a   <= gate_a_next;
            gate_b   <= gate_b_next;
        end
    end

    always_comb begin
        state_next    = state;
        last_next     = last;
        sel_next      = sel;
        grant_next    = grant;
        done_next     = done;
        f_out_next    = f_out;
        op_count_next = op_count;
        gate_a_next   = gate_a;
        gate_b_next   = gate_b;
        case (state)
            IDLE: begin
                done_next = '0;
                if (found) begin
                    sel_next    = pick;
                    gate_a_next = A_bus[pick*WIDTH +: WIDTH];
                    gate_b_next = B_bus[pick*WIDTH +: WIDTH];
                    grant_next  = 4'b0001 << pick;
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                f_out_next    = GateF;
                done_next     = 4'b0001 << sel;
                op_count_next = op_count + 16'd1;
                last_next     = sel;
                state_next    = RESP;
            end
            RESP: begin
                done_next  = '0;
                grant_next = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Grant   = grant;
    assign Done    = done;
    assign F_out   = f_out;
    assign Busy    = (state != IDLE);
    assign OpCount = op_count;
    assign GateA   = gate_a;
    assign GateB   = gate_b;

endmodule
